ysyx_22040237_lsu: RTL
======================

YSYX_22040237_LSU -- requirements
Module: ysyx_22040237_lsu

Interface
REQ-001 SHALL have parameter: ADDR_W, 32, byte-address width of request and memory address.
REQ-002 SHALL have port: clk  in  1  single clock; all state on posedge.
REQ-003 SHALL have port: rst  in  1  reset, synchronous, active-high.
REQ-004 SHALL have ports: req_valid in 1 memory op offered by exu; req_ready out 1 lsu can accept.
REQ-005 SHALL have ports: req_we in 1 store(1)/load(0); req_size in 2 (0=B,1=H,2=W,3=D); req_unsigned in 1 zero-extend load.
REQ-006 SHALL have ports: req_addr in ADDR_W effective address (exu rd_data low bits); req_wdata in 64 store data, right-aligned.
REQ-007 SHALL have ports: resp_valid out 1 one-cycle completion pulse; resp_rdata out 64 extended load data; resp_err out 1 misalign error.
REQ-008 SHALL have ports: mem_valid out 1; mem_ready in 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out 64; mem_wmask out 8; mem_rdata in 64 (valid when mem_ready=1).

Function
REQ-009 SHALL implement FSM IDLE, BUSY, RESP; req_ready=1 only in IDLE.
REQ-010 SHALL, in IDLE with req_valid=1, latch all req_* fields and enter BUSY next cycle; req_* ignored outside IDLE.
REQ-011 SHALL hold mem_valid=1 throughout BUSY, with mem_addr = latched addr with bits[2:0] cleared and mem_we/mem_wdata/mem_wmask stable until mem_ready.
REQ-012 SHALL store: mem_wdata = req_wdata << 8*addr[2:0]; mem_wmask = ((1<<2^size)-1) << addr[2:0], truncated to 8 bits; mem_wmask=0 for loads.
REQ-013 SHALL, in BUSY on mem_ready=1, capture mem_rdata and enter RESP next cycle; mem_valid deasserts in that next cycle.
REQ-014 SHALL load: shift captured data right by 8*addr[2:0], keep 2^size bytes, sign-extend from top kept bit unless req_unsigned=1 (size=3 ignores req_unsigned).
REQ-015 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; resp_rdata=0 for stores; resp_rdata holds last value otherwise.
REQ-016 SHALL give minimum latency: accept at cycle N, mem_valid at N+1, mem_ready at N+1 gives resp_valid at N+2; each extra mem_ready wait cycle adds one.
REQ-017 SHALL have no response back-pressure; exu stalls on !resp_valid.
REQ-018 SHALL, since req_ready=0 in RESP, not accept a new request in the same cycle as resp_valid; next accept is earliest in the following IDLE cycle.

Reset
REQ-019 SHALL, with rst=1 at a posedge, force IDLE, mem_valid=0, resp_valid=0, resp_rdata=0, resp_err=0, latched fields 0.
REQ-020 SHALL abandon any in-flight BUSY access on reset; mem_ready during or after reset in IDLE is ignored.

Configuration
REQ-021 SHALL use macro YSYX_22040237_LSU_MISALIGN_CHK_EN.
REQ-022 SHALL, when defined, flag accepted requests with addr not multiple of 2^size: skip BUSY (no mem_valid), go IDLE->RESP, resp_valid=1, resp_err=1, resp_rdata=0.
REQ-023 SHALL, when undefined, tie resp_err=0 and perform misaligned accesses per REQ-012/014, dropping bytes beyond lane 7.

Verification
REQ-024 SHALL cover: load D addr 0x80000008, mem_rdata 0x1122334455667788, mem_ready at once -> mem_addr 0x80000008, resp_valid at N+2, resp_rdata 0x1122334455667788.
REQ-025 SHALL cover: load B signed addr 0x80000003, mem_rdata 0x00000000_F0000000 -> 0xFFFFFFFFFFFFFFF0; same with req_unsigned=1 -> 0xF0.
REQ-026 SHALL cover: store H addr 0x80000006 wdata 0xABCD -> mem_wmask 0xC0, mem_wdata 0xABCD000000000000, resp_rdata 0.
REQ-027 SHALL cover: mem_ready held 0 for 3 BUSY cycles -> mem_valid/addr/wmask stable 4 cycles, resp_valid at N+5, req_ready=0 throughout.
REQ-028 SHALL cover: rst=1 during BUSY -> next cycle IDLE, mem_valid=0, req_ready=1, no resp_valid for abandoned op.
REQ-029 SHALL cover: macro defined, load W addr 0x80000002 -> no mem_valid, resp_valid at N+1, resp_err=1; undefined -> normal access, resp_err=0.

Source files
------------

// File: rtl/ysyx_22040237_lsu_if.sv
// Bus bundles for ysyx_22040237_lsu: exu request/response side and memory side.
// The exu (master) issues requests to the lsu (slave); the lsu (master) drives memory (slave).
interface ysyx_22040237_lsu_req_if #(parameter int unsigned ADDR_W = 32);
  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [1:0]        req_size;
  logic              req_unsigned;
  logic [ADDR_W-1:0] req_addr;
  logic [63:0]       req_wdata;
  logic              resp_valid;
  logic [63:0]       resp_rdata;
  logic              resp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_err
  );
  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_err
  );
endinterface

interface ysyx_22040237_lsu_mem_if #(parameter int unsigned ADDR_W = 32);
  logic              mem_valid;
  logic              mem_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [63:0]       mem_wdata;
  logic [7:0]        mem_wmask;
  logic [63:0]       mem_rdata;

  modport master (
    output mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
    input  mem_ready, mem_rdata
  );
  modport slave (
    input  mem_valid, mem_we, mem_addr, mem_wdata, mem_wmask,
    output mem_ready, mem_rdata
  );
endinterface

// File: rtl/ysyx_22040237_lsu.sv
// Load/store unit: one outstanding 64-bit memory access, lane alignment and load extension.
// Define YSYX_22040237_LSU_MISALIGN_CHK_EN to reject misaligned requests with resp_err.
module ysyx_22040237_lsu #(
  parameter int unsigned ADDR_W = 32
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_22040237_lsu_req_if.slave   exu,
  ysyx_22040237_lsu_mem_if.master  mem
);

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t            state_q, state_d;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [ADDR_W-1:0] addr_q;
  logic [63:0]       wdata_q;
  logic [63:0]       rdata_q;
  logic              accept;
  logic              misalign;
  logic [63:0]       shifted;
  logic [63:0]       load_ext;
  logic [7:0]        base_mask;

  assign accept = (state_q == IDLE) && exu.req_valid;

`ifdef YSYX_22040237_LSU_MISALIGN_CHK_EN
  logic err_q;

  always_comb begin
    misalign = 1'b0;
    unique case (exu.req_size)
      2'd0:    misalign = 1'b0;
      2'd1:    misalign = exu.req_addr[0];
      2'd2:    misalign = |exu.req_addr[1:0];
      default: misalign = |exu.req_addr[2:0];
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst)         err_q <= 1'b0;
    else if (accept) err_q <= misalign;
  end

  assign exu.resp_err = err_q;
`else
  assign misalign     = 1'b0;
  assign exu.resp_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = misalign ? RESP : BUSY;
      BUSY:    if (mem.mem_ready) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    exu.req_ready  = (state_q == IDLE);
    mem.mem_valid  = (state_q == BUSY);
    exu.resp_valid = (state_q == RESP);
  end

  // Extension is applied at capture time, so rdata_q already holds the final response.
  always_ff @(posedge clk) begin
    if (rst) begin
      we_q    <= 1'b0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      if (accept) begin
        we_q    <= exu.req_we;
        size_q  <= exu.req_size;
        uns_q   <= exu.req_unsigned;
        addr_q  <= exu.req_addr;
        wdata_q <= exu.req_wdata;
        if (misalign) rdata_q <= '0;
      end
      if (state_q == BUSY && mem.mem_ready)
        rdata_q <= we_q ? '0 : load_ext;
    end
  end

  assign shifted = mem.mem_rdata >> {addr_q[2:0], 3'b000};

  always_comb begin
    load_ext = shifted;
    unique case (size_q)
      2'd0:    load_ext = {{56{~uns_q & shifted[7]}},  shifted[7:0]};
      2'd1:    load_ext = {{48{~uns_q & shifted[15]}}, shifted[15:0]};
      2'd2:    load_ext = {{32{~uns_q & shifted[31]}}, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    base_mask = 8'h01;
    unique case (size_q)
      2'd0:    base_mask = 8'h01;
      2'd1:    base_mask = 8'h03;
      2'd2:    base_mask = 8'h0F;
      default: base_mask = 8'hFF;
    endcase
  end

  // Lanes shifted past byte 7 are dropped by the 8-bit truncation.
  assign mem.mem_we    = we_q;
  assign mem.mem_addr  = {addr_q[ADDR_W-1:3], 3'b000};
  assign mem.mem_wdata = wdata_q << {addr_q[2:0], 3'b000};
  assign mem.mem_wmask = we_q ? (base_mask << addr_q[2:0]) : 8'h00;

  assign exu.resp_rdata = rdata_q;

endmodule
